life_display: RTL and testbench

Draws the row of heart icons in the info area and owns the player's life counter. It consumes VGA pixel coordinates and game events, and produces `lifeRequest`/`lifeRGB` for the info-layer display mux. It also exports the current life count and an out-of-lives flag to the game controller. A lost life is shown by blinking the vacated heart for a fixed number of frames.

---
 rtl/life_display.sv | 176 +++++++++++++++++
 tb/tb_life_display.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_display.sv
// Heart-icon row for the info area plus the player's life counter.
// Optional blink of a vacated heart is compiled in when LIFE_BLINK_EN is defined.
module life_display #(
    parameter int          MAX_LIVES     = 5,
    parameter int          INIT_LIVES    = 3,
    parameter int          TOP_LEFT_X    = 16,
    parameter int          TOP_LEFT_Y    = 8,
    parameter int          ICON_PITCH    = 32,
    parameter int          BLINK_FRAMES  = 8,
    parameter int          BLINK_TOGGLES = 6,
    parameter logic [7:0]  HEART_COLOR   = 8'hE0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        lifeLost,
    input  logic        lifeGained,
    input  logic        newGame,
    output logic        lifeRequest,
    output logic [7:0]  lifeRGB,
    output logic [2:0]  livesCount,
    output logic        noLives
);

    localparam int         PITCH_SHIFT = $clog2(ICON_PITCH);
    localparam logic [10:0] X0         = 11'(TOP_LEFT_X);
    localparam logic [10:0] Y0         = 11'(TOP_LEFT_Y);
    localparam logic [10:0] ROW_W      = 11'(MAX_LIVES * ICON_PITCH);
    localparam logic [10:0] OFF_MASK   = 11'(ICON_PITCH - 1);

    function automatic logic [15:0] heart_row(input logic [3:0] y);
        case (y)
            4'd0:    heart_row = 16'b0011110000111100;
            4'd1:    heart_row = 16'b0111111001111110;
            4'd2:    heart_row = 16'b1111111111111111;
            4'd3:    heart_row = 16'b1111111111111111;
            4'd4:    heart_row = 16'b1111111111111111;
            4'd5:    heart_row = 16'b1111111111111111;
            4'd6:    heart_row = 16'b1111111111111111;
            4'd7:    heart_row = 16'b0111111111111110;
            4'd8:    heart_row = 16'b0011111111111100;
            4'd9:    heart_row = 16'b0001111111111000;
            4'd10:   heart_row = 16'b0000111111110000;
            4'd11:   heart_row = 16'b0000011111100000;
            4'd12:   heart_row = 16'b0000001111000000;
            4'd13:   heart_row = 16'b0000000110000000;
            default: heart_row = 16'b0000000000000000;
        endcase
    endfunction

    logic [2:0] livesNext;

`ifdef LIFE_BLINK_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TOG_W   = $clog2(BLINK_TOGGLES + 1);

    typedef enum logic {IDLE, BLINK} state_t;

    state_t             state, stateNext;
    logic [FRAME_W-1:0] frameCnt, frameNext;
    logic [TOG_W-1:0]   toggleCnt, togNext;
    logic               phase, phaseNext;
    logic [2:0]         blinkIdx, blinkIdxNext;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            frameCnt  <= '0;
            toggleCnt <= '0;
            phase     <= 1'b0;
            blinkIdx  <= '0;
        end else begin
            state     <= stateNext;
            frameCnt  <= frameNext;
            toggleCnt <= togNext;
            phase     <= phaseNext;
            blinkIdx  <= blinkIdxNext;
        end
    end

    always_comb begin
        livesNext    = livesCount;
        stateNext    = state;
        frameNext    = frameCnt;
        togNext      = toggleCnt;
        phaseNext    = phase;
        blinkIdxNext = blinkIdx;
        if (newGame) begin
            livesNext = 3'(INIT_LIVES);
            stateNext = IDLE;
            frameNext = '0;
            togNext   = '0;
            phaseNext = 1'b0;
        end else if (lifeLost && !lifeGained && livesCount != 3'd0) begin
            livesNext    = livesCount - 3'd1;
            blinkIdxNext = livesCount - 3'd1;
            stateNext    = BLINK;
            frameNext    = '0;
            togNext      = TOG_W'(BLINK_TOGGLES);
            phaseNext    = 1'b1;
        end else if (lifeGained && !lifeLost) begin
            if (livesCount < 3'(MAX_LIVES))
                livesNext = livesCount + 3'd1;
            stateNext = IDLE;
        end else if (state == BLINK && startOfFrame) begin
            // A cancelled or ignored event still lets the frame tick advance the blink.
            if (frameCnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                frameNext = '0;
                phaseNext = ~phase;
                togNext   = toggleCnt - TOG_W'(1);
                if (toggleCnt == TOG_W'(1))
                    stateNext = IDLE;
            end else begin
                frameNext = frameCnt + FRAME_W'(1);
            end
        end
    end
`else
    logic unusedSof;
    assign unusedSof = startOfFrame;

    always_comb begin
        livesNext = livesCount;
        if (newGame)
            livesNext = 3'(INIT_LIVES);
        else if (lifeLost && !lifeGained && livesCount != 3'd0)
            livesNext = livesCount - 3'd1;
        else if (lifeGained && !lifeLost && livesCount < 3'(MAX_LIVES))
            livesNext = livesCount + 3'd1;
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            livesCount <= 3'(INIT_LIVES);
            noLives    <= (INIT_LIVES == 0);
        end else begin
            livesCount <= livesNext;
            noLives    <= (livesNext == 3'd0);
        end
    end

    logic [10:0] relX, relY, idx, offX;
    logic [15:0] rowBits;
    logic        inRow, bitOn, solidOn, blinkOn, drawn;

    always_comb begin
        relX    = pixelX - X0;
        relY    = pixelY - Y0;
        idx     = relX >> PITCH_SHIFT;
        offX    = relX & OFF_MASK;
        inRow   = (pixelX >= X0) && (relX < ROW_W) && (pixelY >= Y0) && (relY < 11'd16);
        rowBits = heart_row(relY[3:0]);
        bitOn   = (offX < 11'd16) && rowBits[offX[3:0]];
        solidOn = idx < {8'b0, livesCount};
`ifdef LIFE_BLINK_EN
        blinkOn = (state == BLINK) && (idx == {8'b0, blinkIdx}) && phase;
`else
        blinkOn = 1'b0;
`endif
        drawn   = inRow && bitOn && (solidOn || blinkOn);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lifeRequest <= 1'b0;
            lifeRGB     <= '0;
        end else begin
            lifeRequest <= drawn;
            lifeRGB     <= drawn ? HEART_COLOR : 8'h00;
        end
    end

endmodule

// File: tb/tb_life_display.sv
// Randomised bench for life_display with a frame-count based reference model.
// Works with or without LIFE_BLINK_EN defined.
module tb_life_display;

    localparam int         MAXL  = 5;
    localparam int         INIT  = 3;
    localparam int         TLX   = 16;
    localparam int         TLY   = 8;
    localparam int         PITCH = 32;
    localparam int         BF    = 8;
    localparam int         BT    = 6;
    localparam logic [7:0] HC    = 8'hE0;
`ifdef LIFE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        lifeLost = 1'b0;
    logic        lifeGained = 1'b0;
    logic        newGame = 1'b0;
    logic        lifeRequest;
    logic [7:0]  lifeRGB;
    logic [2:0]  livesCount;
    logic        noLives;

    life_display #(
        .MAX_LIVES(MAXL), .INIT_LIVES(INIT), .TOP_LEFT_X(TLX), .TOP_LEFT_Y(TLY),
        .ICON_PITCH(PITCH), .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT), .HEART_COLOR(HC)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .lifeLost(lifeLost), .lifeGained(lifeGained),
        .newGame(newGame), .lifeRequest(lifeRequest), .lifeRGB(lifeRGB),
        .livesCount(livesCount), .noLives(noLives)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] heartRows [16];
    initial begin
        heartRows[0]  = 16'b0011110000111100;
        heartRows[1]  = 16'b0111111001111110;
        for (int r = 2; r <= 6; r++) heartRows[r] = 16'hFFFF;
        heartRows[7]  = 16'b0111111111111110;
        heartRows[8]  = 16'b0011111111111100;
        heartRows[9]  = 16'b0001111111111000;
        heartRows[10] = 16'b0000111111110000;
        heartRows[11] = 16'b0000011111100000;
        heartRows[12] = 16'b0000001111000000;
        heartRows[13] = 16'b0000000110000000;
        heartRows[14] = 16'h0000;
        heartRows[15] = 16'h0000;
    end

    // Blink is modelled as "frames seen since the loss": visible in even 8-frame blocks.
    int mLives, mIdx, mSof, expLives;
    bit mBlink, expReq;
    bit checkEn = 1'b0;

    function automatic bit model_draw(input int x, input int y);
        int rx, ry, idx, off;
        if (x < TLX || y < TLY) return 1'b0;
        rx = x - TLX;
        ry = y - TLY;
        if (rx >= MAXL * PITCH || ry >= 16) return 1'b0;
        idx = rx / PITCH;
        off = rx % PITCH;
        if (off >= 16) return 1'b0;
        if (!heartRows[ry][off]) return 1'b0;
        return (idx < mLives) || (mBlink && idx == mIdx && ((mSof / BF) % 2) == 0);
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mLives = INIT; mBlink = 1'b0; mSof = 0; mIdx = 0;
            expReq = 1'b0; expLives = INIT;
        end else begin
            expReq = model_draw(int'(pixelX), int'(pixelY));
            if (newGame) begin
                mLives = INIT;
                mBlink = 1'b0;
            end else if (lifeLost && !lifeGained && mLives > 0) begin
                mLives = mLives - 1;
                mIdx   = mLives;
                mBlink = BLINK_ON;
                mSof   = 0;
            end else if (lifeGained && !lifeLost) begin
                if (mLives < MAXL) mLives = mLives + 1;
                mBlink = 1'b0;
            end else if (startOfFrame && mBlink) begin
                mSof = mSof + 1;
                if (mSof >= BF * BT) mBlink = 1'b0;
            end
            expLives = mLives;
        end
    end

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            cmp("lifeRequest", int'(lifeRequest), int'(expReq));
            cmp("lifeRGB", int'(lifeRGB), expReq ? int'(HC) : 0);
            cmp("livesCount", int'(livesCount), expLives);
            cmp("noLives", int'(noLives), int'(expLives == 0));
        end
    end

    task automatic drive(input bit l, input bit g, input bit n, input bit s,
                         input int x, input int y);
        @(negedge clk);
        lifeLost = l; lifeGained = g; newGame = n; startOfFrame = s;
        pixelX = 11'(x); pixelY = 11'(y);
    endtask

    task automatic lit(input string name, input int x, input int y, input bit req);
        drive(0, 0, 0, 0, x, y);
        @(posedge clk); #1;
        cmp(name, int'(lifeRequest), int'(req));
    endtask

    task automatic lit_lives(input string name, input int req);
        @(posedge clk); #1;
        cmp(name, int'(livesCount), req);
        cmp({name, "_noLives"}, int'(noLives), int'(req == 0));
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            drive(0, 0, 0, 1, $urandom_range(0, 200), $urandom_range(0, 30));
            repeat (3) drive(0, 0, 0, 0, $urandom_range(0, 200), $urandom_range(0, 30));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 resetN = 1'b1;
        checkEn = 1'b1;

        @(posedge clk); #1;
        cmp("reset_lifeRequest", int'(lifeRequest), 0);
        cmp("reset_lives", int'(livesCount), 3);
        cmp("reset_noLives", int'(noLives), 0);

        lit("h0_bit2", 18, 8, 1'b1);
        lit("h0_bit0", 16, 8, 1'b0);
        lit("h0_gap", 36, 8, 1'b0);
        lit("h2_bit2", 82, 8, 1'b1);
        lit("h3_absent", 114, 8, 1'b0);
        lit("left_of_row", 15, 8, 1'b0);
        for (int x = 0; x < 200; x++) drive(0, 0, 0, 0, x, 8);

        drive(1, 0, 0, 0, 0, 0);
        lit_lives("lost1", 2);
`ifdef LIFE_BLINK_EN
        for (int f = 0; f < 56; f++) begin
            lit("blink_h2", 82, 8, (f < 48) && ((f / 8) % 2 == 0));
            drive(0, 0, 0, 1, $urandom_range(0, 200), $urandom_range(0, 30));
        end
`else
        lit("vacated_h2", 82, 8, 1'b0);
`endif
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        lit_lives("lost_to_zero", 0);
        drive(1, 0, 0, 0, 0, 0);
        lit_lives("lost_at_zero", 0);
        frames(60);
        lit("none_h0", 18, 8, 1'b0);

        drive(0, 0, 1, 0, 0, 0);
        lit_lives("newgame", 3);
        drive(1, 1, 0, 0, 0, 0);
        lit_lives("cancel", 3);
        lit("cancel_h2_solid", 82, 8, 1'b1);
        repeat (6) drive(0, 1, 0, 0, 0, 0);
        lit_lives("saturate", 5);

        drive(1, 0, 0, 0, 0, 0);
        frames(10);
        drive(0, 0, 1, 0, 0, 0);
        lit_lives("newgame_midblink", 3);
        lit("ng_h2_solid", 82, 8, 1'b1);
        lit("ng_h4_absent", 146, 8, 1'b0);

        for (int c = 0; c < 8000; c++) begin
            int x, y;
            if (c == 4000) begin
                @(negedge clk);
                #2 resetN = 1'b0;
                repeat (2) @(negedge clk);
                #2 resetN = 1'b1;
            end
            if ($urandom_range(0, 9) < 8) begin
                x = $urandom_range(0, 200);
                y = $urandom_range(0, 30);
            end else begin
                x = $urandom_range(0, 2047);
                y = $urandom_range(0, 2047);
            end
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 399) == 0, (c % 12) == 0, x, y);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
